// File: rtl/lsu_subword_pkg.sv
// Shared encodings and the address fault classifier for the sub-word load/store unit.
package lsu_subword_pkg;

   localparam int NUM_LANES = 4;
   localparam int LANE_W    = 8;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_RANGE    = 2'b10;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_t;

   typedef enum logic {
      MUX_LOAD  = 1'b0,
      MUX_MERGE = 1'b1
   } mux_op_t;

   // Range beats alignment; the reserved size 11 is checked like a word.
   function automatic logic [1:0] fault_code(input logic [31:0] addr,
                                             input logic [1:0]  size,
                                             input int unsigned aw);
      logic [31:0] hi;
      hi = addr >> aw;
      if (hi != 32'd0)
         return ERR_RANGE;
      if (size == SZ_HALF && addr[0])
         return ERR_MISALIGN;
      if (size[1] && addr[1:0] != 2'b00)
         return ERR_MISALIGN;
      return ERR_NONE;
   endfunction

endpackage

// File: rtl/lsu_subword_if.sv
// CPU + RAM side bus of the load/store unit; master is the CPU/RAM system, slave is the LSU.
interface lsu_subword_if #(parameter int ADDR_W = 12);

   logic              req;
   logic              we;
   logic [1:0]        size;
   logic              sign_ext;
   logic [31:0]       addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              stall;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_din;
   logic [31:0]       ram_dout;
   logic              err;
   logic [1:0]        err_code;
   logic [31:0]       err_addr;
   logic              err_clr;

   modport master (
      output req, we, size, sign_ext, addr, wdata, err_clr, ram_dout,
      input  rdata, stall, ram_we, ram_addr, ram_din, err, err_code, err_addr
   );

   modport slave (
      input  req, we, size, sign_ext, addr, wdata, err_clr, ram_dout,
      output rdata, stall, ram_we, ram_addr, ram_din, err, err_code, err_addr
   );

endinterface

// File: rtl/lsu_subword_lane_mux.sv
// Byte-lane steering: extracts a load result from a word, or merges store data into a word.
module lsu_lane_mux
   import lsu_subword_pkg::*;
(
   input  mux_op_t     op,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   output logic [31:0] dout
);

   logic [NUM_LANES-1:0][LANE_W-1:0] word_l;
   logic [NUM_LANES-1:0][LANE_W-1:0] merged_l;
   logic [7:0]  bsel;
   logic [15:0] hsel;
   logic [31:0] loaded;

   assign word_l = word;

   // Each lane either keeps the old byte or takes the matching store byte.
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam logic [1:0] LANE = 2'(i);
      logic       hit;
      logic [7:0] src;

      assign hit = (size == SZ_BYTE) ? (offset == LANE) :
                   (size == SZ_HALF) ? (offset[1] == LANE[1]) : 1'b1;
      assign src = (size == SZ_BYTE) ? wdata[7:0] :
                   (size == SZ_HALF) ? (LANE[0] ? wdata[15:8] : wdata[7:0]) :
                                       wdata[8*i +: 8];
      assign merged_l[i] = hit ? src : word_l[i];
   end

   always_comb begin
      bsel   = word_l[offset];
      hsel   = offset[1] ? word[31:16] : word[15:0];
      loaded = word;
      case (size)
         SZ_BYTE: loaded = {{24{sign_ext & bsel[7]}}, bsel};
         SZ_HALF: loaded = {{16{sign_ext & hsel[15]}}, hsel};
         default: loaded = word;
      endcase
   end

   assign dout = (op == MUX_MERGE) ? merged_l : loaded;

endmodule

// File: rtl/lsu_subword.sv
// Load/store unit: sub-word loads in zero wait states, sub-word stores as a two-cycle
// read-modify-write, and a sticky first-fault record for misaligned/out-of-range accesses.
module lsu_subword
   import lsu_subword_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input logic          clk,
   input logic          rst,
   lsu_subword_if.slave bus
);

   state_t            state;
   logic [ADDR_W-1:0] saddr_q;
   logic [DATA_W-1:0] merge_q;
   logic              err_q;
   logic [1:0]        err_code_q;
   logic [31:0]       err_addr_q;

   logic              idle;
   logic [1:0]        fcode;
   logic              fault;
   logic              acc;
   logic              ld;
   logic              st_word;
   logic              st_sub;
   logic [DATA_W-1:0] ld_data;
   logic [DATA_W-1:0] mg_data;

   assign idle    = (state == ST_IDLE);
   assign fcode   = fault_code(bus.addr, bus.size, ADDR_W);
   assign fault   = idle & bus.req & (fcode != ERR_NONE);
   assign acc     = idle & bus.req & (fcode == ERR_NONE);
   assign ld      = acc & ~bus.we;
   assign st_word = acc & bus.we & bus.size[1];
   assign st_sub  = acc & bus.we & ~bus.size[1];

   lsu_lane_mux u_load (
      .op       (MUX_LOAD),
      .word     (bus.ram_dout),
      .wdata    (32'd0),
      .offset   (bus.addr[1:0]),
      .size     (bus.size),
      .sign_ext (bus.sign_ext),
      .dout     (ld_data)
   );

   lsu_lane_mux u_merge (
      .op       (MUX_MERGE),
      .word     (bus.ram_dout),
      .wdata    (bus.wdata),
      .offset   (bus.addr[1:0]),
      .size     (bus.size),
      .sign_ext (1'b0),
      .dout     (mg_data)
   );

   // Write enable depends only on state and CPU inputs, never on ram_dout; gating
   // with rst kills a pending WRITE before the RAM's negedge sample.
   assign bus.ram_we   = ~rst & (idle ? st_word : 1'b1);
   assign bus.stall    = ~rst & st_sub;
   assign bus.ram_addr = idle ? bus.addr[ADDR_W-1:0] : saddr_q;
   assign bus.ram_din  = idle ? bus.wdata : merge_q;
   assign bus.rdata    = ld ? ld_data : 32'd0;

   assign bus.err      = err_q;
   assign bus.err_code = err_code_q;
   assign bus.err_addr = err_addr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         saddr_q    <= '0;
         merge_q    <= '0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
         err_addr_q <= 32'd0;
      end else begin
         if (state == ST_WRITE) begin
            state <= ST_IDLE;
         end else if (st_sub) begin
            state   <= ST_WRITE;
            saddr_q <= bus.addr[ADDR_W-1:0];
            merge_q <= mg_data;
         end

         // A clear in the same cycle as a new fault makes room for that fault.
         if (fault && (!err_q || bus.err_clr)) begin
            err_q      <= 1'b1;
            err_code_q <= fcode;
            err_addr_q <= bus.addr;
         end else if (bus.err_clr) begin
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            err_addr_q <= 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_lsu_subword.sv
// Directed bench for lsu_subword with a behavioural negedge-write word RAM.
module tb_lsu_subword;

   logic clk;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   logic [31:0] mem [0:1023];

   lsu_subword_if #(.ADDR_W(12)) bus ();

   lsu_subword #(.ADDR_W(12), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.ram_dout = mem[bus.ram_addr[11:2]];

   always @(negedge clk)
      if (bus.ram_we) mem[bus.ram_addr[11:2]] <= bus.ram_din;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic r, input logic w, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      bus.req      = r;
      bus.we       = w;
      bus.size     = sz;
      bus.sign_ext = sx;
      bus.addr     = a;
      bus.wdata    = d;
      bus.err_clr  = 1'b0;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      mem[0]    = 32'h1fffffff;
      mem[1]    = 32'h10000002;
      mem[1023] = 32'h80000000;
      rst          = 1'b1;
      bus.req      = 1'b0;
      bus.we       = 1'b0;
      bus.size     = 2'b00;
      bus.sign_ext = 1'b0;
      bus.addr     = 32'd0;
      bus.wdata    = 32'd0;
      bus.err_clr  = 1'b0;
      #2;
      chk("rst_stall", {31'd0, bus.stall}, 32'd0);
      chk("rst_ram_we", {31'd0, bus.ram_we}, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      chk("rst_err_code", {30'd0, bus.err_code}, 32'd0);
      chk("rst_err_addr", bus.err_addr, 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // sub-word loads from word 0 = 0x1fffffff
      drive(1, 0, 2'b00, 1, 32'd0, 32'd0);
      chk("lb0", bus.rdata, 32'hffffffff);
      chk("lb0_stall", {31'd0, bus.stall}, 32'd0);
      drive(1, 0, 2'b00, 0, 32'd0, 32'd0);
      chk("lbu0", bus.rdata, 32'h000000ff);
      drive(1, 0, 2'b00, 1, 32'd3, 32'd0);
      chk("lb3", bus.rdata, 32'h0000001f);
      drive(1, 0, 2'b01, 1, 32'd0, 32'd0);
      chk("lh0", bus.rdata, 32'hffffffff);
      drive(1, 0, 2'b01, 0, 32'd2, 32'd0);
      chk("lhu2", bus.rdata, 32'h00001fff);
      chk("lhu2_stall", {31'd0, bus.stall}, 32'd0);

      // sb addr 1
      drive(1, 1, 2'b00, 0, 32'd1, 32'h000000ab);
      chk("sb_c1_stall", {31'd0, bus.stall}, 32'd1);
      chk("sb_c1_we", {31'd0, bus.ram_we}, 32'd0);
      tick();
      chk("sb_c2_stall", {31'd0, bus.stall}, 32'd0);
      chk("sb_c2_we", {31'd0, bus.ram_we}, 32'd1);
      chk("sb_c2_din", bus.ram_din, 32'h1fffabff);
      drive(1, 0, 2'b10, 0, 32'd0, 32'd0);
      chk("lw0_after_sb", bus.rdata, 32'h1fffabff);

      // sh addr 6 into word 4 = 0x10000002
      drive(1, 1, 2'b01, 0, 32'd6, 32'h0000beef);
      chk("sh_c1_stall", {31'd0, bus.stall}, 32'd1);
      tick();
      chk("sh_c2_we", {31'd0, bus.ram_we}, 32'd1);
      chk("sh_c2_din", bus.ram_din, 32'hbeef0002);
      drive(1, 0, 2'b10, 0, 32'd4, 32'd0);
      chk("lw4_after_sh", bus.rdata, 32'hbeef0002);

      // sw addr 8, single cycle
      drive(1, 1, 2'b10, 0, 32'd8, 32'hcafef00d);
      chk("sw_stall", {31'd0, bus.stall}, 32'd0);
      chk("sw_we", {31'd0, bus.ram_we}, 32'd1);
      chk("sw_din", bus.ram_din, 32'hcafef00d);
      drive(1, 0, 2'b10, 0, 32'd8, 32'd0);
      chk("lw8", bus.rdata, 32'hcafef00d);

      // misaligned lh addr 3
      drive(1, 0, 2'b01, 1, 32'd3, 32'd0);
      chk("lh3_rdata", bus.rdata, 32'd0);
      chk("lh3_we", {31'd0, bus.ram_we}, 32'd0);
      chk("lh3_stall", {31'd0, bus.stall}, 32'd0);
      drive(0, 0, 2'b00, 0, 32'd0, 32'd0);
      chk("mis_err", {31'd0, bus.err}, 32'd1);
      chk("mis_code", {30'd0, bus.err_code}, 32'd1);
      chk("mis_addr", bus.err_addr, 32'd3);

      // out-of-range sw while err set: first fault wins
      drive(1, 1, 2'b10, 0, 32'h00002000, 32'h11111111);
      chk("oor_sw_we", {31'd0, bus.ram_we}, 32'd0);
      drive(0, 0, 2'b00, 0, 32'd0, 32'd0);
      chk("first_wins_code", {30'd0, bus.err_code}, 32'd1);
      chk("first_wins_addr", bus.err_addr, 32'd3);

      bus.err_clr = 1'b1;
      drive(0, 0, 2'b00, 0, 32'd0, 32'd0);
      chk("clr_err", {31'd0, bus.err}, 32'd0);
      chk("clr_code", {30'd0, bus.err_code}, 32'd0);
      drive(1, 1, 2'b10, 0, 32'h00002000, 32'h11111111);
      drive(0, 0, 2'b00, 0, 32'd0, 32'd0);
      chk("oor_code", {30'd0, bus.err_code}, 32'd2);
      chk("oor_addr", bus.err_addr, 32'h00002000);

      // clear and new fault in the same cycle: new fault recorded
      drive(1, 0, 2'b01, 1, 32'd1, 32'd0);
      bus.err_clr = 1'b1;
      drive(0, 0, 2'b00, 0, 32'd0, 32'd0);
      chk("clrfault_err", {31'd0, bus.err}, 32'd1);
      chk("clrfault_code", {30'd0, bus.err_code}, 32'd1);
      chk("clrfault_addr", bus.err_addr, 32'd1);

      // more boundaries
      drive(1, 0, 2'b10, 0, 32'd2, 32'd0);
      chk("lw2_mis_rdata", bus.rdata, 32'd0);
      drive(1, 0, 2'b00, 0, 32'h00001000, 32'd0);
      chk("lbu_oor_rdata", bus.rdata, 32'd0);
      drive(1, 0, 2'b00, 0, 32'h00000fff, 32'd0);
      chk("lbu_top", bus.rdata, 32'h00000080);
      drive(1, 0, 2'b00, 1, 32'h00000fff, 32'd0);
      chk("lb_top", bus.rdata, 32'hffffff80);
      chk("err_kept_addr", bus.err_addr, 32'd1);

      // reset during WRITE of sh addr 2
      drive(1, 1, 2'b01, 0, 32'd2, 32'h00001234);
      chk("rstw_c1_stall", {31'd0, bus.stall}, 32'd1);
      @(posedge clk);
      #1;
      rst     = 1'b1;
      bus.req = 1'b0;
      #1;
      chk("rstw_stall", {31'd0, bus.stall}, 32'd0);
      chk("rstw_we", {31'd0, bus.ram_we}, 32'd0);
      chk("rstw_err", {31'd0, bus.err}, 32'd0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      drive(1, 0, 2'b10, 0, 32'd0, 32'd0);
      chk("rstw_word0", bus.rdata, 32'h1fffabff);
      chk("rstw_idle_stall", {31'd0, bus.stall}, 32'd0);

      // back-to-back sb then lw
      drive(1, 1, 2'b00, 0, 32'd4, 32'h0000005a);
      chk("b2b_c1_stall", {31'd0, bus.stall}, 32'd1);
      tick();
      chk("b2b_c2_din", bus.ram_din, 32'hbeef005a);
      drive(1, 0, 2'b10, 0, 32'd4, 32'd0);
      chk("b2b_lw4", bus.rdata, 32'hbeef005a);

      drive(0, 0, 2'b00, 0, 32'd0, 32'd0);
      chk("idle_rdata", bus.rdata, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_subword.md
Name: lsu_subword

Overview:
- Load/store unit between the single-cycle MIPS datapath and the word-addressed data RAM.
- Converts byte and halfword accesses (lb/lbu/lh/lhu/sb/sh) into the RAM's 32-bit word interface.
- Sub-word stores are done as a registered two-cycle read-modify-write, with a stall to the CPU.
- Detects misaligned and out-of-range accesses and holds a sticky error record.

Parameters:
- ADDR_W, 12, RAM byte-address width; legal byte addresses are 0 .. 2^ADDR_W-1.
- DATA_W, 32, word width; fixed at 32, present for documentation only.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  CPU memory access valid this cycle.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  CPU byte address.
- wdata  in  32  store data, right-aligned.
- rdata  out  32  load result, extended to 32 bits.
- stall  out  1  CPU must hold all inputs and not advance its PC.
- ram_we  out  1  RAM write enable; the RAM samples it on negedge clk.
- ram_addr  out  ADDR_W  byte address to the RAM; the RAM ignores bits [1:0].
- ram_din  out  32  word written to the RAM.
- ram_dout  in  32  combinational RAM read data for ram_addr.
- err  out  1  sticky error flag.
- err_code  out  2  01 misaligned, 10 out of range, 00 none.
- err_addr  out  32  address of the first faulting access.
- err_clr  in  1  synchronous clear of err, err_code and err_addr.

Behaviour:
- Byte lanes are little-endian: offset 0 = bits [7:0], offset 3 = bits [31:24].
- Reset values: state IDLE, stall 0, ram_we 0, merge register 0, saved address 0, err 0, err_code 00, err_addr 0.
- rdata is combinational and has no reset value; it is 0 whenever req=0.
- Fault check (combinational):
  - out of range: addr[31:ADDR_W] != 0.
  - misaligned: halfword with addr[0]=1, or word with addr[1:0] != 00.
  - Out of range takes priority over misaligned.
  - A faulting access produces no RAM write, no stall and rdata = 0.
  - If err=0, the fault sets err, err_code and err_addr on the next posedge. If err=1, the record is left unchanged (first fault wins).
  - If err_clr and a new fault occur in the same cycle, the new fault is recorded.
- State IDLE:
  - ram_addr = addr[ADDR_W-1:0].
  - Load: rdata = selected byte or halfword of ram_dout, extended per sign_ext; a word load passes through. Zero wait states, stall=0.
  - Word store: ram_we=1, ram_din=wdata, stall=0; the write lands on this cycle's negedge.
  - Sub-word store:
    - ram_we=0, stall=1.
    - On posedge, capture the address and the merged word (ram_dout with the target lane(s) replaced by wdata[7:0] or wdata[15:0]).
    - Go to WRITE.
  - req=0 or a faulting access: remain in IDLE.
- State WRITE:
  - ram_addr = saved address, ram_din = merge register, ram_we=1, stall=0.
  - CPU inputs are ignored; the CPU retires the store this cycle.
  - Unconditionally return to IDLE.
- Sub-word store latency is exactly 2 cycles. Everything else is 1 cycle.
- Reset mid-operation: asynchronous reset in WRITE forces IDLE immediately. ram_we drops before the next negedge, so no partial write occurs.
- ram_we is decoded from state and inputs only, with no dependence on ram_dout, so there is no combinational loop through the RAM.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - error codes ERR_NONE, ERR_MISALIGN, ERR_RANGE;
  - state encodings ST_IDLE, ST_WRITE.
- One sub-module, lsu_lane_mux: a purely combinational block with two functions, instantiated once for the load path and once for the store merge:
  - load extract: offset, size and sign_ext to rdata;
  - store merge: old word, wdata, offset and size to new word.

Test Plan:
- RAM word 0 = 0x1fffffff. lb addr 0 -> 0xffffffff; lbu addr 0 -> 0x000000ff; lb addr 3 -> 0x0000001f; lh addr 0 -> 0xffffffff; lhu addr 2 -> 0x00001fff. All with stall=0.
- sb addr 1, wdata 0x000000ab, word 0 = 0x1fffffff:
  - cycle 1: stall=1, ram_we=0;
  - cycle 2: stall=0, ram_we=1, ram_din=0x1fffabff;
  - a following lw addr 0 returns 0x1fffabff.
- sh addr 6, wdata 0x0000beef, word 4 = 0x10000002 -> 2-cycle store writes 0xbeef0002. sw addr 8, wdata 0xcafef00d -> single-cycle write, stall=0.
- lh addr 3 -> rdata 0, no write, err=1, err_code=01, err_addr=3. A later sw to addr 0x2000 leaves err_code=01 (first wins). err_clr, then sw to 0x2000 -> err_code=10, err_addr=0x00002000.
- sh addr 2 issued, rst pulsed during WRITE before the negedge -> word 0 unchanged, stall=0, state IDLE, err=0.
- Back-to-back: sb addr 4 immediately followed by lw addr 4 -> the load sees the merged word in the cycle after WRITE.
